// File: rtl/pla_personality_loader.sv
// pla_personality_loader
//   Streams an AND-plane personality in bit by bit over a valid/ready
//   handshake. The bits are stored in an internal N_TERMS x N_IN memory.
//   Once the load completes, the block evaluates the registered product
//   terms from the live inputs on every clock.
//
// Ports
//   clk        : clock, rising edge active
//   rst_n      : asynchronous active-low reset
//   load_start : single-cycle request to (re)start a full personality load
//   cfg_valid  : personality bit present on cfg_bit
//   cfg_bit    : personality bit; the first bit of a row lands in bit N_IN-1
//   cfg_ready  : loader accepts a bit this cycle (high only while loading)
//   load_done  : one-cycle pulse after the final bit has been written
//   a          : array inputs, N_IN wide
//   b          : registered product terms; b[j] is formed from row j
//   b_valid    : b reflects a complete personality
module pla_personality_loader #(
  parameter int N_IN    = 7,
  parameter int N_TERMS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               cfg_valid,
  input  logic               cfg_bit,
  output logic               cfg_ready,
  output logic               load_done,
  input  logic [N_IN-1:0]    a,
  output logic [N_TERMS-1:0] b,
  output logic               b_valid
);

  localparam int BW = $clog2(N_IN) + 1;
  localparam int RW = $clog2(N_TERMS) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(N_IN - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N_TERMS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                         state;
  state_t                         state_nxt;
  logic [BW-1:0]                  bit_cnt;
  logic [RW-1:0]                  row_cnt;
  logic [N_IN-1:0]                row_buf;
  logic [N_IN-1:0]                row_shift;
  logic [N_TERMS-1:0][N_IN-1:0]   mem;
  logic                           accept;
  logic                           bit_last;
  logic                           row_last;

  // An input is "don't care" for a term unless its personality bit is set,
  // so an all-zero row evaluates to 1.
  function automatic logic [N_TERMS-1:0] eval_terms(
    input logic [N_IN-1:0]              in_a,
    input logic [N_TERMS-1:0][N_IN-1:0] pers
  );
    logic [N_TERMS-1:0] t;
    for (int j = 0; j < N_TERMS; j++) begin
      t[j] = &(in_a | ~pers[j]);
    end
    return t;
  endfunction

  assign accept    = (state == LOAD) && cfg_valid;
  assign bit_last  = (bit_cnt == BIT_LAST);
  assign row_last  = (row_cnt == ROW_LAST);
  // Shifting left means the first streamed bit ends up in the MSB.
  assign row_shift = (row_buf << 1) | N_IN'(cfg_bit);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; load_start takes priority over the final beat
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (load_start) state_nxt = LOAD;
      LOAD: begin
        if (load_start)                       state_nxt = LOAD;
        else if (accept && bit_last && row_last) state_nxt = RUN;
      end
      RUN:  if (load_start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cfg_ready = 1'b0;
    if (state == LOAD) cfg_ready = 1'b1;
  end

  // Stage p0: row assembly, memory write, counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      row_cnt   <= '0;
      row_buf   <= '0;
      mem       <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (load_start) begin
        bit_cnt <= '0;
        row_cnt <= '0;
        row_buf <= '0;
      end else if (accept) begin
        if (bit_last) begin
          for (int j = 0; j < N_TERMS; j++) begin
            if (row_cnt == RW'(j)) mem[j] <= row_shift;
          end
          row_buf <= '0;
          bit_cnt <= '0;
          if (row_last) begin
            row_cnt   <= '0;
            load_done <= 1'b1;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end else begin
          row_buf <= row_shift;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Stage p1: registered product terms
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b       <= '0;
      b_valid <= 1'b0;
    end else if ((state == RUN) && !load_start) begin
      b       <= eval_terms(a, mem);
      b_valid <= 1'b1;
    end else begin
      b       <= '0;
      b_valid <= 1'b0;
    end
  end

endmodule
